// File: rtl/sram_master_pkg.sv
// Shared types and strobe constants for the asynchronous SRAM initiator.
// Strobe polarity lives here so the FSM reads in terms of "active"/"inactive".
package sram_master_pkg;

  typedef enum logic [2:0] {
    SRAM_IDLE     = 3'd0,
    SRAM_RD_ACC   = 3'd1,
    SRAM_WR_SETUP = 3'd2,
    SRAM_WR_PULSE = 3'd3,
    SRAM_WR_HOLD  = 3'd4,
    SRAM_DONE     = 3'd5
  } sram_state_t;

  localparam logic SRAM_CE_ACTIVE   = 1'b0;
  localparam logic SRAM_WE_ACTIVE   = 1'b0;
  localparam logic SRAM_OE_ACTIVE   = 1'b0;
  localparam logic SRAM_CE_INACTIVE = 1'b1;
  localparam logic SRAM_WE_INACTIVE = 1'b1;
  localparam logic SRAM_OE_INACTIVE = 1'b1;

  localparam logic [3:0] SRAM_BE_NONE = 4'hF;
  localparam logic [3:0] SRAM_BE_ALL  = 4'h0;

  localparam int CNT_W = 4;

  function automatic logic [3:0] sel_to_be_n(input logic [3:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/sram_master.sv
// Drives an asynchronous SRAM from single-word CPU requests with registered,
// glitch-free CE/OE/WE/BE strobes and a one-cycle completion pulse.
module sram_master
  import sram_master_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [3:0]        req_sel_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_data_oe,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n,
  output logic [2:0]        state_dbg
);

  // Handshake: the CPU raises req_valid_i with a stable request and keeps it
  // up until ack_o; stall_o tells the pipeline to hold until that ack cycle.
  // Any request seen in IDLE is accepted, so the CPU must drop or replace the
  // request during the ack cycle.

  sram_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_cycle;

  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] resp_nxt;
  logic              doe_nxt;
  logic              ce_nxt;
  logic              oe_nxt;
  logic              we_nxt;
  logic [3:0]        be_nxt;
  logic              ack_nxt;

  assign last_cycle = (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign stall_o    = req_valid_i & ~ack_o;
  assign busy_o     = (state != SRAM_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SRAM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SRAM_IDLE:     if (req_valid_i) state_nxt = req_we_i ? SRAM_WR_SETUP : SRAM_RD_ACC;
      SRAM_RD_ACC:   if (last_cycle) state_nxt = SRAM_DONE;
      SRAM_WR_SETUP: state_nxt = SRAM_WR_PULSE;
      SRAM_WR_PULSE: if (last_cycle) state_nxt = SRAM_WR_HOLD;
      SRAM_WR_HOLD:  state_nxt = SRAM_DONE;
      SRAM_DONE:     state_nxt = SRAM_IDLE;
      default:       state_nxt = SRAM_IDLE;
    endcase
    // Counter restarts on every state entry; it only advances in timed states.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (state == SRAM_RD_ACC || state == SRAM_WR_PULSE) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Next values of the registered pins; strobes change only on clock edges.
  always_comb begin
    addr_nxt  = ram_addr_o;
    wdata_nxt = ram_data_o;
    resp_nxt  = resp_data_o;
    doe_nxt   = ram_data_oe;
    ce_nxt    = ram_ce_n;
    oe_nxt    = ram_oe_n;
    we_nxt    = ram_we_n;
    be_nxt    = ram_be_n;
    ack_nxt   = 1'b0;
    case (state)
      SRAM_IDLE: begin
        if (req_valid_i) begin
          addr_nxt  = req_addr_i;
          wdata_nxt = req_data_i;
          ce_nxt    = SRAM_CE_ACTIVE;
          if (req_we_i) begin
            be_nxt  = sel_to_be_n(req_sel_i);
            doe_nxt = 1'b1;
          end else begin
            be_nxt = SRAM_BE_ALL;
            oe_nxt = SRAM_OE_ACTIVE;
          end
        end
      end
      SRAM_RD_ACC: begin
        if (last_cycle) begin
          resp_nxt = ram_data_i;
          ce_nxt   = SRAM_CE_INACTIVE;
          oe_nxt   = SRAM_OE_INACTIVE;
          we_nxt   = SRAM_WE_INACTIVE;
          be_nxt   = SRAM_BE_NONE;
        end
      end
      SRAM_WR_SETUP: we_nxt = SRAM_WE_ACTIVE;
      SRAM_WR_PULSE: if (last_cycle) we_nxt = SRAM_WE_INACTIVE;
      SRAM_WR_HOLD: begin
        ce_nxt  = SRAM_CE_INACTIVE;
        doe_nxt = 1'b0;
        be_nxt  = SRAM_BE_NONE;
      end
      SRAM_DONE: ack_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      resp_data_o <= '0;
      ram_data_oe <= 1'b0;
      ram_ce_n    <= SRAM_CE_INACTIVE;
      ram_oe_n    <= SRAM_OE_INACTIVE;
      ram_we_n    <= SRAM_WE_INACTIVE;
      ram_be_n    <= SRAM_BE_NONE;
      ack_o       <= 1'b0;
    end else begin
      ram_addr_o  <= addr_nxt;
      ram_data_o  <= wdata_nxt;
      resp_data_o <= resp_nxt;
      ram_data_oe <= doe_nxt;
      ram_ce_n    <= ce_nxt;
      ram_oe_n    <= oe_nxt;
      ram_we_n    <= we_nxt;
      ram_be_n    <= be_nxt;
      ack_o       <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with a behavioural byte-lane SRAM model.
module tb_sram_master;
  import sram_master_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_sel;
  logic [31:0] resp_data;
  logic        ack;
  logic        stall;
  logic        busy;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_data_oe;
  logic [31:0] ram_rdata;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [3:0]  ram_be_n;
  logic [2:0]  state_dbg;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  sram_master #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_sel_i(req_sel),
    .resp_data_o(resp_data), .ack_o(ack), .stall_o(stall), .busy_o(busy),
    .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_oe(ram_data_oe),
    .ram_data_i(ram_rdata), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_be_n(ram_be_n), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, byte-lane write while CE and WE are low
  assign ram_rdata = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_be_n[b]) mem[ram_addr[7:0]][b*8 +: 8] = ram_wdata[b*8 +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ((ram_data_oe && !ram_oe_n) || (!ram_we_n && ram_ce_n))) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Presents one request; first tick is the acceptance edge, lat counts edges to ack.
  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, input bit drop, input bit keep,
                         output int lat, output int oe_cnt, output int we_cnt,
                         output int doe_cnt, output int we_first, output int we_last,
                         output logic [3:0] be_seen, output logic stall_ack,
                         output logic first_busy);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    req_sel   = sel;
    lat = -1; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; we_first = -1; we_last = -1;
    be_seen = 4'hF; stall_ack = 1'b1; first_busy = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (cyc == 1) begin
        first_busy = busy;
        if (drop) req_valid = 1'b0;
      end
      if (!ram_oe_n) oe_cnt++;
      if (ram_data_oe) doe_cnt++;
      if (!ram_we_n) begin
        we_cnt++;
        if (we_first < 0) we_first = cyc;
        we_last = cyc;
      end
      if (!ram_ce_n) be_seen = ram_be_n;
      if (ack) begin
        lat = cyc - 1;
        stall_ack = stall;
        if (!keep) req_valid = 1'b0;
        break;
      end
    end
  endtask

  int lat, oe_cnt, we_cnt, doe_cnt, we_first, we_last, extra_ack, extra_busy;
  logic [3:0] be_seen;
  logic stall_ack, first_busy;
  bit found;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_sel = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce_n", ram_ce_n, 1);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_we_n", ram_we_n, 1);
    check("rst_be_n", ram_be_n, 4'hF);
    check("rst_data_oe", ram_data_oe, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_resp", resp_data, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // read 0x00123
    mem[8'h23] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 20'h00123, 32'h0, 4'b0101, 0, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("rd_latency", lat, 3);
    check("rd_oe_cycles", oe_cnt, 2);
    check("rd_we_cycles", we_cnt, 0);
    check("rd_doe_cycles", doe_cnt, 0);
    check("rd_be_n", be_seen, 4'h0);
    check("rd_stall_at_ack", stall_ack, 0);
    check("rd_addr", ram_addr, 20'h00123);
    check("rd_data", resp_data, exp_q.pop_front());
    tick();

    // full write 0x00040
    run_txn(1'b1, 20'h00040, 32'h12345678, 4'b1111, 0, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("wr_latency", lat, 5);
    check("wr_doe_cycles", doe_cnt, 4);
    check("wr_we_cycles", we_cnt, 2);
    check("wr_we_first", we_first, 2);
    check("wr_we_last", we_last, 3);
    check("wr_oe_cycles", oe_cnt, 0);
    check("wr_be_n", be_seen, 4'h0);
    check("wr_mem", mem[8'h40], 32'h12345678);
    check("wr_resp_hold", resp_data, 32'hDEADBEEF);
    tick();

    // byte-lane write
    mem[8'h20] = 32'h11111111;
    run_txn(1'b1, 20'h00020, 32'hAABBCCDD, 4'b0010, 0, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("bw_latency", lat, 5);
    check("bw_be_n", be_seen, 4'b1101);
    check("bw_mem", mem[8'h20], 32'h1111CC11);
    tick();

    // write with no byte enables still completes
    mem[8'h30] = 32'h55555555;
    run_txn(1'b1, 20'h00030, 32'hFFFFFFFF, 4'b0000, 0, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("sel0_latency", lat, 5);
    check("sel0_be_n", be_seen, 4'hF);
    check("sel0_mem", mem[8'h30], 32'h55555555);
    tick();

    // back-to-back write then read of 0x10, request held high throughout
    run_txn(1'b1, 20'h00010, 32'hCAFEF00D, 4'b1111, 0, 1, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("b2b_wr_latency", lat, 5);
    check("b2b_gap_busy", busy, 0);
    check("b2b_gap_ce_n", ram_ce_n, 1);
    check("b2b_gap_oe_n", ram_oe_n, 1);
    check("b2b_gap_we_n", ram_we_n, 1);
    check("b2b_gap_doe", ram_data_oe, 0);
    exp_q.push_back(32'hCAFEF00D);
    run_txn(1'b0, 20'h00010, 32'h0, 4'b1111, 0, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("b2b_rd_started", first_busy, 1);
    check("b2b_rd_latency", lat, 3);
    check("b2b_rd_data", resp_data, exp_q.pop_front());
    tick();

    // request dropped right after acceptance
    run_txn(1'b0, 20'h00123, 32'h0, 4'b1111, 1, 0, lat, oe_cnt, we_cnt, doe_cnt,
            we_first, we_last, be_seen, stall_ack, first_busy);
    check("drop_latency", lat, 3);
    check("drop_data", resp_data, 32'hDEADBEEF);
    extra_ack = 0;
    extra_busy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) extra_ack++;
      if (busy) extra_busy++;
    end
    check("drop_extra_ack", extra_ack, 0);
    check("drop_no_restart", extra_busy, 0);

    // reset in the middle of the write pulse
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00050; req_data = 32'h0; req_sel = 4'hF;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state_dbg == SRAM_WR_PULSE) begin
        found = 1;
        break;
      end
    end
    check("mid_reached_pulse", 32'(found), 1);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_we_n", ram_we_n, 1);
    check("mid_ce_n", ram_ce_n, 1);
    check("mid_doe", ram_data_oe, 0);
    check("mid_ack", ack, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_state", state_dbg, SRAM_IDLE);
    check("post_busy", busy, 0);
    check("post_ack", ack, 0);

    check("bus_rule_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
